tty_serial_tx: RTL
==================

// Module: tty_serial_tx
// PURPOSE
//  Teletype transmitter (M707-style) for the PDP-8/I console path; the sending end of the serial link.
//  Accepts a parallel character from the IOT logic and shifts it out asynchronously on txd.
//  Frame: 1 start bit (space=0), DATA_BITS data bits LSB first, STOP_BITS stop bits (mark=1).
//  Provides the transmit flag used by TSF/TCF/TLS, and an IRQ request.
// PARAMETERS
//  CLK_DIV    9091  clk cycles per bit time (1 MHz / 110 baud); must be >= 2
//  DATA_BITS  8     data bits per frame (1..8)
//  STOP_BITS  2     stop bits per frame (1..2)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  load       in   1  one-cycle strobe: capture data and start a frame (TLS)
//  data       in   8  character; only bits [DATA_BITS-1:0] are sent
//  flag_clr   in   1  one-cycle strobe: clear flag (TCF)
//  flag_set   in   1  one-cycle strobe: set flag (TFL / console init)
//  txd        out  1  serial output, idle mark (1)
//  busy       out  1  1 while a frame is being shifted
//  flag       out  1  transmit-done flag (TSF skip source)
//  irq        out  1  equals flag
// BEHAVIOUR
//  Reset (async, rst_n=0): txd=1, busy=0, flag=0, state=IDLE, counters=0; takes effect at once,
//   aborting any frame in progress. No partial frame is resumed after rst_n rises.
//  State machine: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: txd=1. When load=1, latch data into the shift register, clear the flag,
//    load the bit timer with CLK_DIV-1, and go to START. busy=1 from the next edge.
//   START: txd=0 for exactly CLK_DIV cycles.
//   DATA: txd=shift[0] for CLK_DIV cycles per bit; the register shifts right at each bit boundary.
//    Go to STOP after DATA_BITS bits.
//   STOP: txd=1 for STOP_BITS*CLK_DIV cycles. Then enter IDLE, set flag=1, busy=0 in the same edge.
//  Bit timer: counts down from CLK_DIV-1 to 0. At 0 it reloads and advances the bit or state.
//   A separate bit counter is 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
//  Latency: txd falls on the first edge after load. Frame length is
//   (1+DATA_BITS+STOP_BITS)*CLK_DIV cycles. flag rises on the edge that ends the last stop bit.
//  txd is driven from a register (glitch-free); it does not depend combinationally on inputs.
//  load while busy=1: ignored. The frame in progress and the latched data are unchanged.
//  load with flag_clr in the same cycle: both act; flag=0.
//  Flag priority on one edge: frame completion (set) > flag_set > load/flag_clr (clear).
//   Completion together with flag_clr therefore leaves flag=1.
//  flag_set and flag_clr have no effect on txd/busy. The flag is independent of the shift state.
//  Back-to-back: a load in the first IDLE cycle after completion starts the next frame.
//   txd then stays 1 for that single cycle and goes 0 on the next edge.
// TESTING  (bench uses CLK_DIV=4, DATA_BITS=8, STOP_BITS=2)
//  Reset: rst_n=0 mid-frame -> txd=1, busy=0, flag=0 immediately. After release, txd stays 1 with no strobes.
//  load with data=8'h55 -> txd = 0,1,0,1,0,1,0,1,0,1,1, each held 4 clks.
//   busy=1 for 44 clks; flag=1 on clk 44 after load.
//  load 8'hC3 with DATA_BITS=7 -> data bits 1,1,0,0,0,0,1, then stop 1,1; flag at 40 clks.
//  load 8'hFF during a busy 8'h00 frame -> the frame stays all-zero data; the second load is dropped;
//   a single flag rise.
//  flag_clr on the exact completion edge -> flag=1. Next cycle flag_clr -> flag=0. flag_set -> flag=1, irq=1.
//  Back-to-back: load 8'h41, then load 8'h42 one clk after flag rises -> two contiguous frames
//   with a 1-clk mark gap; the second load clears flag.

Source files
------------

// File: rtl/tty_serial_tx.sv
// Teletype serial transmitter: shifts a parallel character out as an async frame
// (start, LSB-first data, stop bits) and keeps the transmit-done flag / IRQ.
module tty_serial_tx #(
  parameter int CLK_DIV   = 9091,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       flag_clr,
  input  logic       flag_set,
  output logic       txd,
  output logic       busy,
  output logic       flag,
  output logic       irq
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLK_DIV - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          flag_q, flag_d;
  logic          tick;
  logic          accept;
  logic          done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    accept    = 1'b0;
    done      = 1'b0;
    tick      = (timer_q == '0);

    if (state_q != S_IDLE) begin
      timer_d = tick ? TIMER_RELOAD : (timer_q - TW'(1));
    end

    // txd_d is the line level for the cycle after this edge, so txd stays a pure flop
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (load) begin
          accept    = 1'b1;
          shift_d   = data;
          timer_d   = TIMER_RELOAD;
          bit_cnt_d = '0;
          state_d   = S_START;
          txd_d     = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            state_d   = S_STOP;
            bit_cnt_d = '0;
            txd_d     = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            timer_d   = '0;
            done      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Completion wins over an explicit set, which wins over any clear
  always_comb begin
    flag_d = flag_q;
    if (done) begin
      flag_d = 1'b1;
    end else if (flag_set) begin
      flag_d = 1'b1;
    end else if (accept || flag_clr) begin
      flag_d = 1'b0;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != S_IDLE);
  assign flag = flag_q;
  assign irq  = flag_q;

endmodule
